// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control definitions: ALU_SEL codes, ALUOp classes, function
// fields and the encoded FIFO entry. Used by both the control decoder and
// the control encoder.
package alu_ctrl_pkg;

  // ALU_SEL operation codes
  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;

  // ALUOp instruction classes
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

  // R-type function fields
  localparam logic [5:0] FUNC_NONE = 6'b000000;
  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;

  // One queued control word as presented on the alu_control bus
  typedef struct packed {
    logic [1:0] aluop;
    logic [5:0] func;
  } alu_entry_t;

endpackage

// File: rtl/alu_enc_fifo.sv
// Generic synchronous FIFO: registered memory, wrap-around pointers and an
// occupancy counter. Push while full and pop while empty are ignored.
module alu_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
  // pointers wrap modulo DEPTH by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage write; contents need no reset because an empty FIFO masks them.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_ctrl_encoder.sv
// ALU control encoder: turns a requested ALU_SEL code into the ALUOp /
// function-field pair the control decoder expects, queued in a small FIFO.
// Optional feature macro: ALU_ENC_ERRCNT_EN adds the 8-bit saturating
// illegal-request counter and its err_cnt port.
module alu_ctrl_encoder
  import alu_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_sel,
  input  logic       req_short,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] ALUOp,
  output logic [5:0] func_field,
  output logic       err_illegal,
  input  logic       err_clr
`ifdef ALU_ENC_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  alu_entry_t enc_d;
  alu_entry_t head;
  logic       enc_legal;
  logic       fifo_full, fifo_empty;
  logic       accept, push, pop, ill_acc;
  logic       err_illegal_q;

  // Encode the request; short forms exist only for ADD and SUB.
  always_comb begin
    enc_d     = '{aluop: ALUOP_LDST, func: FUNC_NONE};
    enc_legal = 1'b1;
    case (req_sel)
      SEL_ADD: enc_d = req_short ? '{ALUOP_LDST, FUNC_NONE}
                                 : '{ALUOP_RTYPE, FUNC_ADD};
      SEL_SUB: enc_d = req_short ? '{ALUOP_BRANCH, FUNC_NONE}
                                 : '{ALUOP_RTYPE, FUNC_SUB};
      SEL_AND: enc_d = '{ALUOP_RTYPE, FUNC_AND};
      SEL_OR:  enc_d = '{ALUOP_RTYPE, FUNC_OR};
      SEL_SLT: enc_d = '{ALUOP_RTYPE, FUNC_SLT};
      SEL_NOR: enc_d = '{ALUOP_RTYPE, FUNC_NOR};
      default: enc_legal = 1'b0;
    endcase
  end

  assign req_ready = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign accept    = req_valid & req_ready;
  assign push      = accept & enc_legal;
  assign ill_acc   = accept & ~enc_legal;
  assign pop       = out_valid & out_ready;

  alu_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(alu_entry_t))
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push),
    .wdata_i (enc_d),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Stale storage must not leak onto the bus while nothing is queued.
  assign ALUOp      = out_valid ? head.aluop : '0;
  assign func_field = out_valid ? head.func  : '0;

  // Sticky illegal flag; a new illegal accept wins over a clear.
  always_ff @(posedge clk) begin
    if (rst)          err_illegal_q <= 1'b0;
    else if (ill_acc) err_illegal_q <= 1'b1;
    else if (err_clr) err_illegal_q <= 1'b0;
  end

  assign err_illegal = err_illegal_q;

`ifdef ALU_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating illegal counter; clear plus illegal accept restarts at 1.
  always_ff @(posedge clk) begin
    if (rst)                          err_cnt_q <= '0;
    else if (err_clr)                 err_cnt_q <= {7'd0, ill_acc};
    else if (ill_acc && ~&err_cnt_q)  err_cnt_q <= err_cnt_q + 1'b1;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
// Bench for alu_ctrl_encoder: table of request vectors with expected
// encodings, a queue scoreboard of accepted entries, and hand sequences
// for fill/drain, streaming, error and reset corners.
module tb_alu_ctrl_encoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_short, out_valid, out_ready;
  logic       err_illegal, err_clr;
  logic [3:0] req_sel;
  logic [1:0] ALUOp;
  logic [5:0] func_field;
`ifdef ALU_ENC_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  alu_ctrl_encoder #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_sel     (req_sel),
    .req_short   (req_short),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALUOp       (ALUOp),
    .func_field  (func_field),
    .err_illegal (err_illegal),
    .err_clr     (err_clr)
`ifdef ALU_ENC_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  typedef struct {
    logic [3:0] sel;
    logic       shrt;
    bit         legal;
    logic [7:0] exp;   // {ALUOp, func_field}
  } tv_t;

  tv_t        tv [12];
  logic [7:0] sb_q [$];
  int         n_cmp = 0, n_bad = 0;
  bit         m_err;
  int         m_cnt;
  bit         cur_legal, last_acc;
  logic [7:0] cur_exp;

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every output against the model state
  task automatic check_out(input string tag);
    cmp({tag, " req_ready"}, int'(req_ready), int'(sb_q.size() < DEPTH));
    cmp({tag, " out_valid"}, int'(out_valid), int'(sb_q.size() != 0));
    cmp({tag, " head"}, int'({ALUOp, func_field}),
        (sb_q.size() != 0) ? int'(sb_q[0]) : 0);
    cmp({tag, " err_illegal"}, int'(err_illegal), int'(m_err));
`ifdef ALU_ENC_ERRCNT_EN
    cmp({tag, " err_cnt"}, int'(err_cnt), m_cnt);
`endif
  endtask

  // Check, advance the model with the current inputs, then clock once
  task automatic tick(input string tag);
    bit acc, pp, ill;
    check_out(tag);
    acc = req_valid && (sb_q.size() < DEPTH);
    pp  = out_ready && (sb_q.size() != 0);
    ill = acc && !cur_legal;
    last_acc = acc;
    @(posedge clk); #1;
    if (rst) begin
      sb_q.delete();
      m_err = 0;
      m_cnt = 0;
    end else begin
      if (pp) void'(sb_q.pop_front());
      if (acc && cur_legal) sb_q.push_back(cur_exp);
      if (err_clr) begin
        m_err = ill;
        m_cnt = ill ? 1 : 0;
      end else if (ill) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  endtask

  task automatic drive(input int i);
    req_valid = 1'b1;
    req_sel   = tv[i].sel;
    req_short = tv[i].shrt;
    cur_legal = tv[i].legal;
    cur_exp   = tv[i].exp;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_sel   = 4'b0000;
    req_short = 1'b0;
  endtask

  int r6 [6] = '{0, 3, 4, 5, 6, 7};

  initial begin
    tv[0]  = '{4'b0010, 1'b0, 1'b1, 8'hA0};  // ADD R-type
    tv[1]  = '{4'b0010, 1'b1, 1'b1, 8'h00};  // ADD short
    tv[2]  = '{4'b0110, 1'b1, 1'b1, 8'h40};  // SUB short
    tv[3]  = '{4'b0110, 1'b0, 1'b1, 8'hA2};  // SUB R-type
    tv[4]  = '{4'b0000, 1'b0, 1'b1, 8'hA4};  // AND
    tv[5]  = '{4'b0001, 1'b1, 1'b1, 8'hA5};  // OR, short ignored
    tv[6]  = '{4'b0111, 1'b0, 1'b1, 8'hAA};  // SLT
    tv[7]  = '{4'b1100, 1'b1, 1'b1, 8'hA7};  // NOR, short ignored
    tv[8]  = '{4'b1111, 1'b0, 1'b0, 8'h00};  // illegal
    tv[9]  = '{4'b0011, 1'b1, 1'b0, 8'h00};  // illegal
    tv[10] = '{4'b0000, 1'b1, 1'b1, 8'hA4};  // AND, short ignored
    tv[11] = '{4'b0111, 1'b1, 1'b1, 8'hAA};  // SLT, short ignored

    rst = 1'b1; out_ready = 1'b0; err_clr = 1'b0; cur_legal = 1'b1;
    cur_exp = 8'h00; idle();
    @(posedge clk); #1;
    sb_q.delete(); m_err = 0; m_cnt = 0;
    check_out("reset");
    cmp("reset ALUOp", int'(ALUOp), 0);
    rst = 1'b0;

    // First ADD: visible one cycle after accept
    drive(0); tick("add");
    idle();
    cmp("add lat out_valid", int'(out_valid), 1);
    cmp("add lat ALUOp", int'(ALUOp), 2);
    cmp("add lat func", int'(func_field), 6'b100000);
    out_ready = 1'b1; tick("add pop"); out_ready = 1'b0;

    // SUB short then SUB R-type
    drive(2); tick("sub s");
    drive(3); tick("sub r");
    idle();
    cmp("sub head", int'({ALUOp, func_field}), 8'h40);
    out_ready = 1'b1; tick("sub pop1");
    cmp("sub head2", int'({ALUOp, func_field}), 8'hA2);
    tick("sub pop2"); out_ready = 1'b0;

    // Fill to full with R-type codes, then drain
    for (int k = 0; k < 4; k++) begin drive(r6[k]); tick("fill"); end
    cmp("full req_ready", int'(req_ready), 0);
    drive(r6[4]); tick("full hold");
    cmp("full still", int'(req_ready), 0);
    out_ready = 1'b1;
    begin
      int idx = 4;
      for (int c = 0; c < 20 && idx < 6; c++) begin
        drive(r6[idx]); tick("refill");
        if (last_acc) idx++;
      end
      cmp("refill done", idx, 6);
    end
    idle();
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick("drain");
    out_ready = 1'b0;
    cmp("drained", int'(out_valid), 0);

    // Table sweep, one request at a time
    for (int i = 0; i < 12; i++) begin
      drive(i); tick("tbl");
      idle();
      cmp("tbl out_valid", int'(out_valid), int'(tv[i].legal));
      if (tv[i].legal) cmp("tbl head", int'({ALUOp, func_field}), int'(tv[i].exp));
      else             cmp("tbl err", int'(err_illegal), 1);
      out_ready = 1'b1; tick("tbl pop"); out_ready = 1'b0;
      err_clr = 1'b1; tick("tbl clr"); err_clr = 1'b0;
    end

    // Streaming push+pop every cycle, pointers wrap several times
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(c % 8); tick("stream");
      cmp("stream valid", int'(out_valid), 1);
      cmp("stream ready", int'(req_ready), 1);
    end
    idle(); tick("stream end"); out_ready = 1'b0;

    // Illegal request, then clear together with another illegal
    drive(8); tick("ill");
    idle();
    cmp("ill out_valid", int'(out_valid), 0);
    cmp("ill flag", int'(err_illegal), 1);
`ifdef ALU_ENC_ERRCNT_EN
    cmp("ill cnt", int'(err_cnt), 1);
`endif
    drive(9); err_clr = 1'b1; tick("ill clr");
    err_clr = 1'b0; idle();
    cmp("ill clr flag", int'(err_illegal), 1);
`ifdef ALU_ENC_ERRCNT_EN
    cmp("ill clr cnt", int'(err_cnt), 1);
`endif

    // Counter saturation
    for (int c = 0; c < 260; c++) begin drive(8); tick("sat"); end
    idle();
`ifdef ALU_ENC_ERRCNT_EN
    cmp("sat cnt", int'(err_cnt), 255);
`endif
    err_clr = 1'b1; tick("sat clr"); err_clr = 1'b0;
    cmp("sat clr flag", int'(err_illegal), 0);

    // Reset with three entries queued and the error flag set
    drive(8); tick("pre rst ill");
    drive(0); tick("q0");
    drive(3); tick("q1");
    drive(4); tick("q2");
    idle();
    cmp("pre rst valid", int'(out_valid), 1);
    rst = 1'b1; tick("rst"); rst = 1'b0;
    cmp("rst out_valid", int'(out_valid), 0);
    cmp("rst head", int'({ALUOp, func_field}), 0);
    cmp("rst err", int'(err_illegal), 0);
    out_ready = 1'b1; tick("rst pop empty");
    check_out("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_encoder.md
# alu_ctrl_encoder

Inverse of the ALU control decoder. Accepts a requested 4-bit ALU operation code (ALU_SEL encoding) and produces the matching `ALUOp`/`func_field` pair that the decoder consumes. Requests are buffered in a small FIFO with valid/ready handshakes on both sides. The block sits between the instruction sequencer/test driver and the `alu_control` input bus.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; equals `!full`.
- `req_sel`  in  4  requested ALU_SEL code.
- `req_short`  in  1  prefer the short (non-R-type) form where one exists.
- `out_valid`  out  1  encoded pair available at the FIFO head.
- `out_ready`  in  1  consumer takes the head entry.
- `ALUOp`  out  2  encoded ALUOp.
- `func_field`  out  6  encoded function field.
- `err_illegal`  out  1  sticky flag: an unsupported `req_sel` was accepted.
- `err_clr`  in  1  clears `err_illegal` and the error counter.
- `err_cnt`  out  8  illegal-request counter; present only with `ALU_ENC_ERRCNT_EN`.

## Operation
- Encoding is performed at enqueue. Each FIFO entry stores 8 bits: {ALUOp, func_field}.
- 0010 ADD: `req_short`=1 → 00/000000; otherwise 10/100000.
- 0110 SUB: `req_short`=1 → 01/000000; otherwise 10/100010.
- 0000 AND → 10/100100. 0001 OR → 10/100101. 0111 SLT → 10/101010. 1100 NOR → 10/100111. `req_short` is ignored for these codes.
- Any other `req_sel` is illegal:
  - The request is still accepted (handshake completes).
  - Nothing is written to the FIFO.
  - `err_illegal` is set to 1 and the counter increments.
- Push occurs when `req_valid & req_ready` and the code is legal.
- Pop occurs when `out_valid & out_ready`.
- `out_valid` = FIFO not empty. When `out_valid`=0, `ALUOp`/`func_field` are forced to 00/000000.
- The counter saturates at 255.
- Simultaneous `err_clr` and an illegal accept: `err_illegal` ends at 1 and the counter ends at 1.

## Timing
- Reset values:
  - `req_ready`=1, `out_valid`=0, `ALUOp`=00, `func_field`=000000.
  - `err_illegal`=0, `err_cnt`=0.
  - Pointers and occupancy are 0.
- Reset mid-operation discards all FIFO contents.
- Latency: a request accepted in cycle N appears with `out_valid`=1 in cycle N+1, provided the FIFO was empty. There is no same-cycle bypass.
- Push and pop in the same cycle leave occupancy unchanged. Wrap-around is handled by pointer increment modulo `DEPTH`.
- Full (occupancy = `DEPTH`):
  - `req_ready`=0, so no push is possible, even if a pop happens in the same cycle.
  - `req_ready` returns to 1 in the cycle after the pop.
- Empty: a pop request is ignored, and occupancy never underflows.
- Occupancy register is $clog2(DEPTH)+1 bits wide.
- Outputs are driven from registered storage. Output changes occur only after a clock edge.

## Configuration
- `ALU_ENC_ERRCNT_EN` defined:
  - The 8-bit saturating `err_cnt` port and register exist.
  - The counter is cleared by `rst` and by `err_clr`.
- `ALU_ENC_ERRCNT_EN` undefined:
  - The `err_cnt` port and register are absent.
  - `err_illegal` behaviour is unchanged.

## Structure
- Shared package `alu_ctrl_pkg` holds:
  - ALU_SEL code constants (AND, OR, ADD, SUB, SLT, NOR).
  - ALUOp constants (00 load/store, 01 branch, 10 R-type).
  - Function-field constants (100000, 100010, 100100, 100101, 100111, 101010).
  - The 8-bit entry type.
- The decoder uses the same package.
- Sub-module `alu_enc_fifo` is a generic synchronous FIFO with `DEPTH` and `WIDTH` parameters. It has push/pop/full/empty and a registered memory.
- Encoding logic stays in the top module.

## Test plan
- Reset, then `req_sel`=0010, `req_short`=0, `out_ready`=0 → next cycle `out_valid`=1, `ALUOp`=10, `func_field`=100000.
- 0110 with `req_short`=1, then 0110 with `req_short`=0 → heads 01/000000 then 10/100010.
- Push all six legal codes (R-type form) with `out_ready`=0:
  - `req_ready` drops to 0 after 4 accepts.
  - Then set `out_ready`=1 → first four entries drain in order and `req_ready` returns.
  - The remaining two are accepted afterwards.
- Continuous `req_valid` and `out_ready` for 20 cycles → occupancy stays 1 and there is one output per cycle (wrap-around exercised).
- `req_sel`=1111 → no FIFO entry, `out_valid` stays 0, `err_illegal`=1, `err_cnt`=1. Then `err_clr` together with another illegal request → `err_illegal`=1, `err_cnt`=1.
- Assert `rst` with 3 entries queued → next cycle `out_valid`=0, outputs 00/000000, `err_illegal`=0.
